// File: rtl/segre_main_memory.sv
// segre_main_memory: lane-read / posted-write main memory responder.
// Reads return one LANE_SIZE lane after RD_LATENCY cycles with a
// one-cycle data_rdy_o pulse; writes (BYTE/HALF/WORD) commit at once.
//
// Ports:
//   clk_i, rsn_i            clock, async active-low reset
//   rd_i, rd_addr_i         read request (level) and byte address
//   wr_i, wr_addr_i,
//   wr_data_i,
//   wr_data_type_i          posted write strobe, address, data, size
//   data_rdy_o, rd_data_o   response pulse and little-endian lane

package segre_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } memop_data_type_e;

endpackage

module segre_main_memory
   import segre_pkg::*;
#(
   parameter int unsigned ADDR_SIZE  = 32,
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned LANE_SIZE  = 128,
   parameter int unsigned MEM_BYTES  = 65536,
   parameter int unsigned RD_LATENCY = 8,
   parameter string       INIT_FILE  = ""
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 rd_i,
   input  logic [ADDR_SIZE-1:0] rd_addr_i,
   input  logic                 wr_i,
   input  logic [ADDR_SIZE-1:0] wr_addr_i,
   input  logic [WORD_SIZE-1:0] wr_data_i,
   input  memop_data_type_e     wr_data_type_i,
   output logic                 data_rdy_o,
   output logic [LANE_SIZE-1:0] rd_data_o
);

   localparam int unsigned LANE_BYTES = LANE_SIZE / 8;
   localparam int unsigned OFS_W      = $clog2(LANE_BYTES);
   localparam int unsigned IDX_W      = $clog2(MEM_BYTES);
   localparam int unsigned WB         = WORD_SIZE / 8;
   localparam int unsigned WB_W       = $clog2(WB);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_e;

   state_e               state_q;
   state_e               state_d;
   logic [7:0]           cnt_q;
   logic [7:0]           cnt_d;
   logic [IDX_W-1:0]     lane_q;
   logic [IDX_W-1:0]     lane_d;
   logic                 cap;

   logic [7:0]           mem [MEM_BYTES];

   logic [IDX_W-1:0]     wr_base;
   logic [WB-1:0]        wr_be;
   logic [LANE_SIZE-1:0] lane_view;

   logic                 unused_addr;

   assign unused_addr = ^{rd_addr_i[ADDR_SIZE-1:IDX_W],
                          rd_addr_i[OFS_W-1:0],
                          wr_addr_i[ADDR_SIZE-1:IDX_W]};

   // Sub-word writes are aligned down to their natural size, so a
   // write never straddles a word boundary.
   always_comb begin
      wr_base = wr_addr_i[IDX_W-1:0];
      wr_be   = WB'(1);
      unique case (wr_data_type_i)
         HALF: begin
            wr_base[0] = 1'b0;
            wr_be      = WB'(3);
         end
         WORD: begin
            wr_base[WB_W-1:0] = '0;
            wr_be             = '1;
         end
         default: begin
            wr_be = WB'(1);
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (wr_i) begin
         for (int i = 0; i < WB; i++) begin
            if (wr_be[i]) begin
               mem[wr_base + IDX_W'(i)] <= wr_data_i[8*i +: 8];
            end
         end
      end
   end

   // Lane as it will look after this edge: storage overlaid with the
   // write committing on the same edge.
   always_comb begin
      lane_view = '0;
      for (int j = 0; j < LANE_BYTES; j++) begin
         lane_view[8*j +: 8] = mem[lane_d + IDX_W'(j)];
         for (int i = 0; i < WB; i++) begin
            if (wr_i && wr_be[i] &&
                (wr_base + IDX_W'(i) == lane_d + IDX_W'(j))) begin
               lane_view[8*j +: 8] = wr_data_i[8*i +: 8];
            end
         end
      end
   end

   // The counter hits zero on the capture edge; with a latency of one
   // the capture happens on the acceptance edge itself.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      cap     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_i) begin
               lane_d = {rd_addr_i[IDX_W-1:OFS_W], {OFS_W{1'b0}}};
               cnt_d  = 8'(RD_LATENCY - 1);
               if (RD_LATENCY == 1) begin
                  cap     = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               cap     = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lane_q    <= '0;
         rd_data_o <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         if (cap) begin
            rd_data_o <= lane_view;
         end
      end
   end

   assign data_rdy_o = (state_q == RESP);

endmodule

// File: tb/tb_segre_main_memory.sv
// tb_segre_main_memory: directed bench for segre_main_memory.
// Two instances (latency 8 and 1) share stimulus and a byte-array model.

module tb_segre_main_memory;
   import segre_pkg::*;

   localparam int M = 65536;

   logic             clk;
   logic             rsn;
   logic             rd;
   logic [31:0]      rd_addr;
   logic             wr;
   logic [31:0]      wr_addr;
   logic [31:0]      wr_data;
   memop_data_type_e wr_type;
   logic             rdy_a;
   logic             rdy_b;
   logic [127:0]     data_a;
   logic [127:0]     data_b;

   int vectors = 0;
   int miscompares = 0;

   segre_main_memory #(.RD_LATENCY(8)) u_dut_a (
      .clk_i          (clk),
      .rsn_i          (rsn),
      .rd_i           (rd),
      .rd_addr_i      (rd_addr),
      .wr_i           (wr),
      .wr_addr_i      (wr_addr),
      .wr_data_i      (wr_data),
      .wr_data_type_i (wr_type),
      .data_rdy_o     (rdy_a),
      .rd_data_o      (data_a)
   );

   segre_main_memory #(.RD_LATENCY(1)) u_dut_b (
      .clk_i          (clk),
      .rsn_i          (rsn),
      .rd_i           (rd),
      .rd_addr_i      (rd_addr),
      .wr_i           (wr),
      .wr_addr_i      (wr_addr),
      .wr_data_i      (wr_data),
      .wr_data_type_i (wr_type),
      .data_rdy_o     (rdy_b),
      .rd_data_o      (data_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]   mm [M];
   int           ecnt = 0;
   int           lat [2] = '{8, 1};
   int           rdy_at [2] = '{-1, -1};
   int           free_at [2] = '{0, 0};
   logic [31:0]  lbase [2];
   logic [127:0] exp_d [2] = '{128'd0, 128'd0};
   bit           exp_r [2] = '{1'b0, 1'b0};

   function automatic void mwrite(logic [31:0] a, logic [31:0] d,
                                  memop_data_type_e t);
      logic [31:0] b;
      int n;
      case (t)
         HALF: begin b = a & ~32'h1; n = 2; end
         WORD: begin b = a & ~32'h3; n = 4; end
         default: begin b = a; n = 1; end
      endcase
      for (int i = 0; i < n; i++) mm[(b + i) % M] = d[8*i +: 8];
   endfunction

   function automatic logic [127:0] lane_of(logic [31:0] b);
      logic [127:0] r;
      for (int j = 0; j < 16; j++) r[8*j +: 8] = mm[(b + j) % M];
      return r;
   endfunction

   // Accepted at edge n: lane captured at edge n+L-1 (after that
   // edge's write), pulse follows it, next accept at edge n+L+1.
   initial begin
      forever begin
         @(posedge clk);
         if (!rsn) begin
            for (int d = 0; d < 2; d++) begin
               rdy_at[d]  = -1;
               free_at[d] = 0;
               exp_r[d]   = 1'b0;
               exp_d[d]   = '0;
            end
         end else begin
            if (wr) mwrite(wr_addr, wr_data, wr_type);
            for (int d = 0; d < 2; d++) begin
               if (rd && ecnt >= free_at[d]) begin
                  rdy_at[d]  = ecnt + lat[d] - 1;
                  free_at[d] = ecnt + lat[d] + 1;
                  lbase[d]   = (rd_addr & ~32'hF) % M;
               end
               exp_r[d] = (ecnt == rdy_at[d]);
               if (exp_r[d]) exp_d[d] = lane_of(lbase[d]);
            end
         end
         ecnt++;
         #1;
         chk($sformatf("c%0d_rdy_a", ecnt), 128'(rdy_a), 128'(exp_r[0]));
         chk($sformatf("c%0d_dat_a", ecnt), data_a, exp_d[0]);
         chk($sformatf("c%0d_rdy_b", ecnt), 128'(rdy_b), 128'(exp_r[1]));
         chk($sformatf("c%0d_dat_b", ecnt), data_b, exp_d[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr_op(input logic [31:0] a, input logic [31:0] d,
                        input memop_data_type_e t);
      @(negedge clk);
      wr = 1'b1; wr_addr = a; wr_data = d; wr_type = t;
      @(negedge clk);
      wr = 1'b0;
   endtask

   // Holds rd until the latency-8 instance responds; ka/kb count
   // negedges from the request to each instance's first pulse.
   task automatic do_read(input logic [31:0] a, input bit with_wr,
                          input logic [31:0] wa, input logic [31:0] wd,
                          input memop_data_type_e wt,
                          output int ka, output int kb,
                          output logic [127:0] da,
                          output logic [127:0] db);
      ka = -1; kb = -1; da = '0; db = '0;
      @(negedge clk);
      rd = 1'b1; rd_addr = a;
      if (with_wr) begin
         wr = 1'b1; wr_addr = wa; wr_data = wd; wr_type = wt;
      end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         wr = 1'b0;
         if (kb < 0 && rdy_b) begin kb = k; db = data_b; end
         if (rdy_a) begin ka = k; da = data_a; break; end
      end
      rd = 1'b0;
      if (ka < 0) chk("read_timeout", 128'd0, 128'd1);
      idle(3);
   endtask

   localparam logic [127:0] L00 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] L10 = 128'hAA1E1D1C_1B1A1918_17161234_DEADBEEF;
   localparam logic [127:0] L20 = 128'h5A2E2D2C_2B2A2928_CAFEF00D_23222120;
   localparam logic [127:0] L30 = 128'h3F3E3D3C_3B3A3938_37363534_33323130;
   localparam logic [127:0] L40 = 128'h4F4E4D4C_4B4A4948_47464544_43424140;
   localparam logic [127:0] L08 = 128'h0F0E0D0C_00000001_07060504_03020100;
   localparam logic [127:0] L60 = 128'h6F6E6D6C_6B6A6968_67666564_63627760;

   initial begin
      int ka, kb, n;
      logic [127:0] da, db;
      int pk[$];
      logic [127:0] pd[$];

      rsn = 1'b1; rd = 1'b0; rd_addr = '0;
      wr = 1'b0; wr_addr = '0; wr_data = '0; wr_type = BYTE;
      #2 rsn = 1'b0;
      idle(3);
      chk("reset_rdy_a", 128'(rdy_a), 128'd0);
      chk("reset_dat_a", data_a, 128'd0);
      chk("reset_rdy_b", 128'(rdy_b), 128'd0);
      rsn = 1'b1;

      for (int a = 0; a < 256; a += 4)
         wr_op(a, {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)}, WORD);

      // lane at 0x0, unaligned request address
      do_read(32'h4, 1'b0, 0, 0, BYTE, ka, kb, da, db);
      chk("t1_lat_a", 128'(ka), 128'd8);
      chk("t1_lat_b", 128'(kb), 128'd1);
      chk("t1_lane_a", da, L00);
      chk("t1_lane_b", db, L00);

      // mixed-size writes, misaligned HALF
      wr_op(32'h10, 32'hDEADBEEF, WORD);
      wr_op(32'h15, 32'h00001234, HALF);
      wr_op(32'h1F, 32'h000000AA, BYTE);
      do_read(32'h10, 1'b0, 0, 0, BYTE, ka, kb, da, db);
      chk("t2_lane_a", da, L10);
      chk("t2_lane_b", db, L10);

      // write in BUSY plus write forwarded on the capture edge
      @(negedge clk);
      rd = 1'b1; rd_addr = 32'h20;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         wr = 1'b0;
         if (k == 3) begin
            wr = 1'b1; wr_addr = 32'h24; wr_data = 32'hCAFEF00D;
            wr_type = WORD;
         end
         if (k == 7) begin
            wr = 1'b1; wr_addr = 32'h2F; wr_data = 32'h5A;
            wr_type = BYTE;
         end
         if (k == 8) begin
            chk("t3_rdy", 128'(rdy_a), 128'd1);
            chk("t3_lane", data_a, L20);
            rd = 1'b0;
         end
      end
      idle(3);

      // rd held 20 cycles; address change in BUSY ignored
      @(negedge clk);
      rd = 1'b1; rd_addr = 32'h30;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 3) rd_addr = 32'h40;
         if (rdy_a) begin pk.push_back(k); pd.push_back(data_a); end
      end
      rd = 1'b0;
      chk("t4_npulse", 128'(pk.size()), 128'd2);
      if (pk.size() == 2) begin
         chk("t4_p0", 128'(pk[0]), 128'd8);
         chk("t4_p1", 128'(pk[1]), 128'd17);
         chk("t4_d0", pd[0], L30);
         chk("t4_d1", pd[1], L40);
      end
      idle(12);

      // reset in BUSY aborts the read
      @(negedge clk);
      rd = 1'b1; rd_addr = 32'h50;
      idle(4);
      rsn = 1'b0;
      rd = 1'b0;
      #1;
      chk("t5_rdy_a", 128'(rdy_a), 128'd0);
      chk("t5_dat_a", data_a, 128'd0);
      chk("t5_dat_b", data_b, 128'd0);
      idle(2);
      rsn = 1'b1;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rdy_a || rdy_b) n++;
      end
      chk("t5_nopulse", 128'(n), 128'd0);
      do_read(32'h10, 1'b0, 0, 0, BYTE, ka, kb, da, db);
      chk("t5_lat", 128'(ka), 128'd8);
      chk("t5_lane", da, L10);

      // address wrap, latency-1 instance
      wr_op(M + 32'h8, 32'h1, WORD);
      do_read(32'h8, 1'b0, 0, 0, BYTE, ka, kb, da, db);
      chk("t6_lat_b", 128'(kb), 128'd1);
      chk("t6_lane_b", db, L08);
      chk("t6_lane_a", da, L08);

      // read and write on the same IDLE edge
      do_read(32'h60, 1'b1, 32'h61, 32'h77, BYTE, ka, kb, da, db);
      chk("t7_lane_a", da, L60);
      chk("t7_lane_b", db, L60);
      chk("t7_lat_a", 128'(ka), 128'd8);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
